pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage SPARC-subset core. It generates the load enables for PC, nPC and IF/ID, and the select for the ID-stage control-signal NOP mux. It also generates a global hold for ID/EX, EX/MEM and MEM/WB. It handles three cases: load-use stalls, annulled branch delay slots, and data-memory wait states with a timeout.

## Interface
Parameters:
- MEM_TIMEOUT, default 15: maximum consecutive wait cycles tolerated on a data-memory access before the access is abandoned.
- CNT_W, default 16: width of the stall counter. Only present with the macro described under Configuration.

Ports:
- Clk  in  1  Single clock; all state updates on the rising edge.
- R  in  1  Reset, synchronous, active-low (R=0 at a rising Clk edge resets all state).
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_rs2_used  in  1  1 when the ID instruction reads rs2 (i bit = 0).
- id_rd  in  5  rd field of the instruction in ID.
- id_store  in  1  1 when the ID instruction is a store, which reads rd.
- ex_load  in  1  load_instr control bit currently in EX.
- ex_rf_en  in  1  RF_enable control bit currently in EX.
- ex_rd  in  5  Destination register of the instruction in EX.
- id_branch  in  1  B_instr control bit from the control unit.
- id_annul  in  1  Annul bit a (Instr[29]) of the ID branch.
- id_ba  in  1  1 when the ID branch is Branch Always (cond = 1000).
- branch_taken  in  1  Branch condition result for the ID branch.
- mem_dm_en  in  1  DataMem_enable bit currently in MEM.
- dm_ready  in  1  Data memory completes the access this cycle.
- pc_le  out  1  Load enable for PC.
- npc_le  out  1  Load enable for nPC.
- if_id_le  out  1  Load enable for IF/ID.
- cs_nop  out  1  Drives S of the control-signal mux; 1 injects all-zero control signals into ID/EX.
- pipe_hold  out  1  Holds ID/EX, EX/MEM and MEM/WB.
- mem_err  out  1  Sticky flag, set when a memory access times out.

## Operation
Detection terms:
- Load-use hazard `lu` = ex_load & ex_rf_en & (ex_rd≠0) & ((id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd) | (id_store & id_rd==ex_rd)).
- Memory-wait term `mw` = mem_dm_en & ~dm_ready.
- Annul-set term `as` = id_branch & id_annul & (~branch_taken | id_ba).

FSM states are RUN and WAIT. There is a wait timer `tmr` (4 bits min, wide enough for MEM_TIMEOUT) and a flag `annul_pending`.
- RUN, mw=1: go to WAIT, tmr←1.
- WAIT, dm_ready=1: go to RUN, tmr←0.
- WAIT, dm_ready=0 and tmr<MEM_TIMEOUT: stay in WAIT, tmr←tmr+1.
- WAIT, dm_ready=0 and tmr==MEM_TIMEOUT: go to RUN, tmr←0, mem_err←1.

Freeze `frz` = mw & ~(state==WAIT & tmr==MEM_TIMEOUT).

Output priority, highest first:
1. frz: pipe_hold=1; pc_le=npc_le=if_id_le=0; cs_nop=0; annul_pending held.
2. annul_pending: cs_nop=1; all LEs=1; annul_pending←0. The delay-slot instruction is discarded, so `lu` is ignored (no stall).
3. lu: cs_nop=1; pc_le=npc_le=if_id_le=0; pipe_hold=0. The bubble enters EX and the ID instruction is held.
4. Otherwise: all LEs=1; cs_nop=0; pipe_hold=0.

annul_pending←1 only when `as`=1 and if_id_le=1 this cycle.

## Timing
- While R=0, outputs are forced to pc_le=npc_le=if_id_le=0, cs_nop=1, pipe_hold=0.
- At a reset edge: state←RUN, tmr←0, annul_pending←0, mem_err←0.
- After R returns high, the first cycle has all LEs=1 and cs_nop=0. mem_err reads 0 out of reset.
- Load-use costs exactly one stall cycle. The following cycle the load is in MEM and `lu` is false.
- Annul is applied in the cycle immediately after the branch leaves ID. It is deferred across any frz cycles.
- A memory access with N wait cycles (N<MEM_TIMEOUT) freezes for N cycles. A timed-out access freezes for exactly MEM_TIMEOUT cycles, then is released.
- mem_err clears only on reset.
- `mw` and `lu` in the same cycle: frz wins. `lu` is re-evaluated after release.
- Reset asserted during WAIT: returns to RUN and drops the hold at that edge.

## Configuration
- HAZARD_STALL_CNT_EN defined: adds output port `stall_cycles` (out, CNT_W) and a counter behind it.
  - The counter increments on every cycle with (frz | (lu & ~annul_pending)).
  - It saturates at all-ones and resets to 0.
- HAZARD_STALL_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Load into r5 in EX, ID reads rs1=5 → one cycle with cs_nop=1 and pc_le=0, then normal flow. Repeat with ex_rd=0 → no stall.
- ID store with id_rd=7, EX load to r7, rs1 and rs2 unrelated → one-cycle stall.
- BA with a=1 in ID → next cycle cs_nop=1 regardless of lu. Taken BNE with a=1 → no annul. Untaken BNE with a=1 → annul.
- mem_dm_en=1, dm_ready low for 3 cycles → pipe_hold=1 for 3 cycles, release on the 4th. With MEM_TIMEOUT=15 and dm_ready never asserted → 15 hold cycles, then mem_err=1 stays set.
- Annul pending coincident with a 2-cycle memory wait → cs_nop=1 in the first cycle after the wait ends. R=0 pulsed mid-WAIT → pipe_hold=0 and state=RUN next cycle.
- With HAZARD_STALL_CNT_EN: one load-use stall plus a 3-cycle wait → stall_cycles=4.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, annulled delay slots and data-memory waits with timeout.
// Optional macro HAZARD_STALL_CNT_EN adds a saturating stall_cycles counter output.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
`ifdef HAZARD_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       Clk,
  input  logic       R,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_store,
  input  logic       ex_load,
  input  logic       ex_rf_en,
  input  logic [4:0] ex_rd,
  input  logic       id_branch,
  input  logic       id_annul,
  input  logic       id_ba,
  input  logic       branch_taken,
  input  logic       mem_dm_en,
  input  logic       dm_ready,
  output logic       pc_le,
  output logic       npc_le,
  output logic       if_id_le,
  output logic       cs_nop,
  output logic       pipe_hold,
  output logic       mem_err
`ifdef HAZARD_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam int TW = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

  typedef enum logic [0:0] {RUN, WAIT} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic          annul_pending, annul_pending_nxt;
  logic          mem_err_nxt;
  logic          lu, mw, as_term, frz;

  assign lu = ex_load & ex_rf_en & (ex_rd != 5'd0) &
              ((id_rs1 == ex_rd) | (id_rs2_used & (id_rs2 == ex_rd)) | (id_store & (id_rd == ex_rd)));
  assign mw      = mem_dm_en & ~dm_ready;
  assign as_term = id_branch & id_annul & (~branch_taken | id_ba);
  // The final timeout cycle releases the freeze even though the access never completed.
  assign frz     = mw & ~((state == WAIT) & (tmr == TMAX));

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    mem_err_nxt = mem_err;
    case (state)
      RUN: begin
        if (mw) begin
          state_nxt = WAIT;
          tmr_nxt   = TW'(1);
        end
      end
      WAIT: begin
        if (dm_ready) begin
          state_nxt = RUN;
          tmr_nxt   = '0;
        end else if (tmr < TMAX) begin
          tmr_nxt = tmr + TW'(1);
        end else begin
          state_nxt   = RUN;
          tmr_nxt     = '0;
          mem_err_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        tmr_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    pc_le     = 1'b1;
    npc_le    = 1'b1;
    if_id_le  = 1'b1;
    cs_nop    = 1'b0;
    pipe_hold = 1'b0;
    if (!R) begin
      pc_le    = 1'b0;
      npc_le   = 1'b0;
      if_id_le = 1'b0;
      cs_nop   = 1'b1;
    end else if (frz) begin
      pc_le     = 1'b0;
      npc_le    = 1'b0;
      if_id_le  = 1'b0;
      pipe_hold = 1'b1;
    end else if (annul_pending) begin
      cs_nop = 1'b1;
    end else if (lu) begin
      pc_le    = 1'b0;
      npc_le   = 1'b0;
      if_id_le = 1'b0;
      cs_nop   = 1'b1;
    end
    annul_pending_nxt = frz ? annul_pending : (as_term & if_id_le);
  end

  always_ff @(posedge Clk) begin
    if (!R) begin
      state         <= RUN;
      tmr           <= '0;
      annul_pending <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      tmr           <= tmr_nxt;
      annul_pending <= annul_pending_nxt;
      mem_err       <= mem_err_nxt;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Counts frozen cycles plus genuine load-use bubbles; saturates instead of wrapping.
  always_ff @(posedge Clk) begin
    if (!R) begin
      stall_cycles <= '0;
    end else if ((frz | (lu & ~annul_pending)) && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl; checks stalls, annuls, memory waits and timeout.
// Define HAZARD_STALL_CNT_EN to also check the stall_cycles counter.
module tb_pipeline_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       R = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, ex_rd = '0;
  logic       id_rs2_used = 1'b0, id_store = 1'b0, ex_load = 1'b0, ex_rf_en = 1'b0;
  logic       id_branch = 1'b0, id_annul = 1'b0, id_ba = 1'b0, branch_taken = 1'b0;
  logic       mem_dm_en = 1'b0, dm_ready = 1'b0;
  logic       pc_le, npc_le, if_id_le, cs_nop, pipe_hold, mem_err;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  logic [4:0] obs;
  assign obs = {pc_le, npc_le, if_id_le, cs_nop, pipe_hold};

  // {pc_le, npc_le, if_id_le, cs_nop, pipe_hold}
  localparam logic [4:0] OUT_RUN   = 5'b11100;
  localparam logic [4:0] OUT_STALL = 5'b00010;
  localparam logic [4:0] OUT_FRZ   = 5'b00001;
  localparam logic [4:0] OUT_ANNUL = 5'b11110;

  int tests_run = 0;
  int tests_failed = 0;

  pipeline_hazard_ctrl dut (
    .Clk(Clk), .R(R),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_store(id_store), .ex_load(ex_load), .ex_rf_en(ex_rf_en), .ex_rd(ex_rd),
    .id_branch(id_branch), .id_annul(id_annul), .id_ba(id_ba), .branch_taken(branch_taken),
    .mem_dm_en(mem_dm_en), .dm_ready(dm_ready),
    .pc_le(pc_le), .npc_le(npc_le), .if_id_le(if_id_le), .cs_nop(cs_nop),
    .pipe_hold(pipe_hold), .mem_err(mem_err)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_rd = '0;
    id_rs2_used = 0; id_store = 0; ex_load = 0; ex_rf_en = 0;
    id_branch = 0; id_annul = 0; id_ba = 0; branch_taken = 0;
    mem_dm_en = 0; dm_ready = 0;
  endtask

  task automatic test_reset();
    idle();
    R = 1'b0;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_STALL) begin tests_failed++; $display("[TB] FAIL reset_outputs: got %b expected %b", obs, OUT_STALL); end
    tick();
    R = 1'b1;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL post_reset_run: got %b expected %b", obs, OUT_RUN); end
    tests_run++;
    if (mem_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_mem_err: got %b expected 0", mem_err); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ex_load = 1; ex_rf_en = 1; ex_rd = 5'd5; id_rs1 = 5'd5;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_STALL) begin tests_failed++; $display("[TB] FAIL lu_rs1_stall: got %b expected %b", obs, OUT_STALL); end
    tick();
    ex_load = 0; ex_rf_en = 0; ex_rd = 5'd0;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL lu_after_bubble: got %b expected %b", obs, OUT_RUN); end
    tick();
    ex_load = 1; ex_rf_en = 1; ex_rd = 5'd0; id_rs1 = 5'd0;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL lu_r0_no_stall: got %b expected %b", obs, OUT_RUN); end
    tick();
    idle();
    ex_load = 1; ex_rf_en = 1; ex_rd = 5'd9; id_rs1 = 5'd1; id_rs2 = 5'd9; id_rs2_used = 0;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL lu_rs2_unused: got %b expected %b", obs, OUT_RUN); end
    id_rs2_used = 1;
    #1;
    tests_run++;
    if (obs !== OUT_STALL) begin tests_failed++; $display("[TB] FAIL lu_rs2_used: got %b expected %b", obs, OUT_STALL); end
    tick();
    idle();
  endtask

  task automatic test_store();
    idle();
    ex_load = 1; ex_rf_en = 1; ex_rd = 5'd7;
    id_store = 1; id_rd = 5'd7; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rs2_used = 1;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_STALL) begin tests_failed++; $display("[TB] FAIL store_rd_stall: got %b expected %b", obs, OUT_STALL); end
    tick();
    ex_load = 0; ex_rf_en = 0; ex_rd = 5'd0;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL store_after_bubble: got %b expected %b", obs, OUT_RUN); end
    tick();
    idle();
  endtask

  task automatic test_annul();
    idle();
    id_branch = 1; id_annul = 1; id_ba = 1; branch_taken = 1;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL ba_branch_cycle: got %b expected %b", obs, OUT_RUN); end
    tick();
    idle();
    ex_load = 1; ex_rf_en = 1; ex_rd = 5'd3; id_rs1 = 5'd3;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_ANNUL) begin tests_failed++; $display("[TB] FAIL ba_annul_ignores_lu: got %b expected %b", obs, OUT_ANNUL); end
    tick();
    idle();
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL ba_annul_one_cycle: got %b expected %b", obs, OUT_RUN); end
    tick();
    id_branch = 1; id_annul = 1; id_ba = 0; branch_taken = 1;
    tick();
    idle();
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL bne_taken_no_annul: got %b expected %b", obs, OUT_RUN); end
    tick();
    id_branch = 1; id_annul = 1; id_ba = 0; branch_taken = 0;
    tick();
    idle();
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_ANNUL) begin tests_failed++; $display("[TB] FAIL bne_untaken_annul: got %b expected %b", obs, OUT_ANNUL); end
    tick();
  endtask

  task automatic test_mem_wait();
    idle();
    mem_dm_en = 1; dm_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      tests_run++;
      if (obs !== OUT_FRZ) begin tests_failed++; $display("[TB] FAIL mem_wait_hold[%0d]: got %b expected %b", i, obs, OUT_FRZ); end
      tick();
    end
    dm_ready = 1;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL mem_wait_release: got %b expected %b", obs, OUT_RUN); end
    tick();
    idle();
  endtask

  task automatic test_timeout();
    idle();
    mem_dm_en = 1; dm_ready = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      tests_run++;
      if (obs !== OUT_FRZ) begin tests_failed++; $display("[TB] FAIL timeout_hold[%0d]: got %b expected %b", i, obs, OUT_FRZ); end
      tick();
    end
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL timeout_release: got %b expected %b", obs, OUT_RUN); end
    tick();
    idle();
    @(negedge Clk);
    tests_run++;
    if (mem_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_mem_err_set: got %b expected 1", mem_err); end
    tick();
    tick();
    @(negedge Clk);
    tests_run++;
    if (mem_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_mem_err_sticky: got %b expected 1", mem_err); end
    tick();
  endtask

  task automatic test_annul_mem();
    idle();
    id_branch = 1; id_annul = 1; branch_taken = 0;
    tick();
    idle();
    mem_dm_en = 1; dm_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      tests_run++;
      if (obs !== OUT_FRZ) begin tests_failed++; $display("[TB] FAIL annul_mem_hold[%0d]: got %b expected %b", i, obs, OUT_FRZ); end
      tick();
    end
    dm_ready = 1;
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_ANNUL) begin tests_failed++; $display("[TB] FAIL annul_after_wait: got %b expected %b", obs, OUT_ANNUL); end
    tick();
    idle();
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL annul_after_wait_clear: got %b expected %b", obs, OUT_RUN); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    idle();
    mem_dm_en = 1; dm_ready = 0;
    tick();
    tick();
    R = 1'b0;
    @(negedge Clk);
    tests_run++;
    if (pipe_hold !== 1'b0) begin tests_failed++; $display("[TB] FAIL wait_reset_hold: got %b expected 0", pipe_hold); end
    tick();
    R = 1'b1;
    idle();
    @(negedge Clk);
    tests_run++;
    if (obs !== OUT_RUN) begin tests_failed++; $display("[TB] FAIL wait_reset_run: got %b expected %b", obs, OUT_RUN); end
    tests_run++;
    if (mem_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL wait_reset_mem_err: got %b expected 0", mem_err); end
    tick();
    // A full-length timeout afterwards shows the timer restarted from zero.
    test_timeout();
  endtask

`ifdef HAZARD_STALL_CNT_EN
  task automatic test_stall_cnt();
    idle();
    R = 1'b0;
    tick();
    R = 1'b1;
    tick();
    ex_load = 1; ex_rf_en = 1; ex_rd = 5'd4; id_rs1 = 5'd4;
    tick();
    idle();
    mem_dm_en = 1; dm_ready = 0;
    tick(); tick(); tick();
    dm_ready = 1;
    tick();
    idle();
    @(negedge Clk);
    tests_run++;
    if (stall_cycles !== 16'd4) begin tests_failed++; $display("[TB] FAIL stall_cnt: got %0d expected 4", stall_cycles); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_store();
    test_annul();
    test_mem_wait();
    test_timeout();
    test_annul_mem();
    test_reset_in_wait();
`ifdef HAZARD_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
